poly_ram_port: RTL



---
 rtl/poly_pkg.sv | 25 ++
 rtl/poly_bram.sv | 38 +++
 rtl/poly_ram_port.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared sizes, command codes and FSM states for poly_ram_port
// ST_ZERO exists only when POLY_RAM_ZERO_EN is defined.
package poly_pkg;

    localparam int N  = 512;
    localparam int W  = 16;
    localparam int AW = 9;

    localparam logic [1:0] CMD_LOAD_A = 2'b00;
    localparam logic [1:0] CMD_LOAD_B = 2'b01;
    localparam logic [1:0] CMD_RUN    = 2'b10;
    localparam logic [1:0] CMD_UNLOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_UNLOAD = 3'd3
`ifdef POLY_RAM_ZERO_EN
        ,
        ST_ZERO   = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/poly_bram.sv
// rtl/poly_bram.sv - simple dual-port RAM, one write port, registered read-first read port
// The read register holds its value when re is low so it can double as an output stage.
module poly_bram #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-edge sampling of mem gives the pre-write value on an address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/poly_ram_port.sv
// rtl/poly_ram_port.sv - two-bank polynomial RAM responder with host load/unload and engine run sequencing
// Optional ZERO command (clear both banks) is enabled by defining POLY_RAM_ZERO_EN.
module poly_ram_port #(
    parameter int N  = poly_pkg::N,
    parameter int W  = poly_pkg::W,
    parameter int AW = poly_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          eng_start,
    input  logic          eng_done,
    input  logic          eng_we,
    input  logic [AW-1:0] eng_addr,
    input  logic [W-1:0]  eng_din,
    output logic [W-1:0]  eng_doa,
    output logic [W-1:0]  eng_dob
);
    import poly_pkg::*;

    localparam logic [AW:0] CNT_LAST = (AW+1)'(N - 1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(N);

    state_e      state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [AW:0] rd_q, rd_d;
    logic        sel_b_q, sel_b_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        start_q, start_d;
    logic        ov_q, ov_d;

    logic          a_we, b_we, re;
    logic [AW-1:0] a_waddr, raddr;
    logic [W-1:0]  a_wdata, b_wdata, a_rdata, b_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        sel_b_d = sel_b_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        start_d = 1'b0;
        ov_d    = ov_q;
        a_we    = 1'b0;
        b_we    = 1'b0;
        a_waddr = cnt_q[AW-1:0];
        a_wdata = in_data;
        b_wdata = in_data;
        re      = 1'b0;
        raddr   = rd_q[AW-1:0];
        case (state_q)
            ST_IDLE: begin
                ov_d = 1'b0;
                if (cmd_valid) begin
                    cnt_d = '0;
                    rd_d  = '0;
                    case (cmd)
                        CMD_LOAD_A: begin state_d = ST_LOAD; sel_b_d = 1'b0; end
                        CMD_LOAD_B: begin state_d = ST_LOAD; sel_b_d = 1'b1; end
                        CMD_RUN:    begin state_d = ST_RUN;  start_d = 1'b1; end
`ifdef POLY_RAM_ZERO_EN
                        CMD_UNLOAD: state_d = in_valid ? ST_ZERO : ST_UNLOAD;
`else
                        CMD_UNLOAD: state_d = ST_UNLOAD;
`endif
                        default:    err_d = 1'b1;
                    endcase
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    a_we  = !sel_b_q;
                    b_we  = sel_b_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                re      = 1'b1;
                raddr   = eng_addr;
                a_we    = eng_we;
                a_waddr = eng_addr;
                a_wdata = eng_din;
                if (eng_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_UNLOAD: begin
                // Refill the output register only when it is empty or being drained.
                if (!ov_q || out_ready) begin
                    if (rd_q != CNT_FULL) begin
                        re   = 1'b1;
                        rd_d = rd_q + 1'b1;
                        ov_d = 1'b1;
                    end else begin
                        ov_d = 1'b0;
                    end
                end
                if (ov_q && out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        ov_d    = 1'b0;
                    end
                end
            end
`ifdef POLY_RAM_ZERO_EN
            ST_ZERO: begin
                a_we    = 1'b1;
                b_we    = 1'b1;
                a_wdata = '0;
                b_wdata = '0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            sel_b_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            sel_b_q <= sel_b_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            ov_q    <= ov_d;
        end
    end

    poly_bram #(.DEPTH(N), .WIDTH(W), .AWIDTH(AW)) u_bank_a (
        .clk   (clk),
        .rst   (rst),
        .we    (a_we),
        .waddr (a_waddr),
        .wdata (a_wdata),
        .re    (re),
        .raddr (raddr),
        .rdata (a_rdata)
    );

    poly_bram #(.DEPTH(N), .WIDTH(W), .AWIDTH(AW)) u_bank_b (
        .clk   (clk),
        .rst   (rst),
        .we    (b_we),
        .waddr (cnt_q[AW-1:0]),
        .wdata (b_wdata),
        .re    (re),
        .raddr (raddr),
        .rdata (b_rdata)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = ov_q;
    assign out_data  = a_rdata;
    assign eng_start = start_q;
    assign eng_doa   = a_rdata;
    assign eng_dob   = b_rdata;

endmodule
